// File: rtl/alu_arbiter_if.sv
// Purpose: request/response bundle between two requesters, one response consumer
//          and the alu_arbiter.
// Signals:
//   req0_valid/req0_ready/req0_op/req0_a/req0_b  requester 0 channel
//   req1_valid/req1_ready/req1_op/req1_a/req1_b  requester 1 channel
//   rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_carry  shared response channel
// Modports: master = requesters + consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned W = 4
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_out;
    logic         rsp_carry;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_carry
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: shares one 4-bit ALU (ADD/EQ/SHR/NEG/AND) between two requesters.
//          Round-robin or fixed-priority grant, one op in flight, registered
//          response tagged with the issuing requester.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_arbiter_if slave: two request channels + response channel
//   busy   high whenever the FSM is not idle
module alu_arbiter #(
    parameter bit          RR_EN = 1'b1,
    parameter int unsigned W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e       state_q;
    logic         rr_last_q;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_out_q;
    logic         rsp_carry_q;
    logic         busy_q;

    logic         gnt0;
    logic         gnt1;
    logic [W:0]   sum;
    logic [W-1:0] alu_out;

    // Grants only exist in idle; rst_n gating keeps ready low while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && rst_n) begin
            if (RR_EN) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    // Grant whoever was not served last.
                    gnt0 = rr_last_q;
                    gnt1 = ~rr_last_q;
                end else begin
                    gnt0 = bus.req0_valid;
                    gnt1 = bus.req1_valid;
                end
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid & ~bus.req0_valid;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // ALU on the latched operands; carry is the add carry regardless of op.
    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        case (op_q)
            3'b000:  alu_out = sum[W-1:0];
            3'b001:  alu_out = (a_q == b_q) ? '1 : '0;
            3'b010:  alu_out = a_q >> 1;
            3'b011:  alu_out = (~b_q) + 1'b1;
            3'b100:  alu_out = a_q & b_q;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_last_q   <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_carry_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        op_q      <= gnt1 ? bus.req1_op : bus.req0_op;
                        a_q       <= gnt1 ? bus.req1_a  : bus.req0_a;
                        b_q       <= gnt1 ? bus.req1_b  : bus.req0_b;
                        id_q      <= gnt1;
                        rr_last_q <= gnt1;
                        busy_q    <= 1'b1;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    rsp_out_q   <= alu_out;
                    rsp_carry_q <= sum[W];
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter. One round-robin instance carries
//          most of the traffic; a fixed-priority instance checks req0 precedence.
//          Expected responses are queued at request time and popped by monitors.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic busy_rr;
    logic busy_fp;

    always #5 clk = ~clk;

    alu_arbiter_if #(.W(4)) rr_if ();
    alu_arbiter_if #(.W(4)) fp_if ();

    alu_arbiter #(.RR_EN(1'b1), .W(4)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr_if.slave),
        .busy  (busy_rr)
    );

    alu_arbiter #(.RR_EN(1'b0), .W(4)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp_if.slave),
        .busy  (busy_fp)
    );

    typedef struct packed {
        logic       rid;
        logic       rcarry;
        logic [3:0] rout;
    } rsp_t;

    rsp_t rr_q[$];
    rsp_t fp_q[$];
    rsp_t rr_e;
    rsp_t fp_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   fp_r1_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: {carry, result}.
    function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        logic [3:0] r;
        int s;
        s = int'(a) + int'(b);
        case (op)
            3'd0:    r = 4'(s);
            3'd1:    r = (a == b) ? 4'hF : 4'h0;
            3'd2:    r = {1'b0, a[3:1]};
            3'd3:    r = 4'(16 - int'(b));
            3'd4:    r = a & b;
            default: r = 4'h0;
        endcase
        return {(s > 15), r};
    endfunction

    function automatic rsp_t mk(input logic id, input logic [2:0] op, input logic [3:0] a,
                                input logic [3:0] b);
        rsp_t x;
        logic [4:0] m;
        m        = alu_model(op, a, b);
        x.rid    = id;
        x.rcarry = m[4];
        x.rout   = m[3:0];
        return x;
    endfunction

    // Response monitors.
    always @(negedge clk) begin
        if (rst_n && rr_if.rsp_valid && rr_if.rsp_ready) begin
            if (rr_q.size() == 0) begin
                chk("rr_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rr_e = rr_q.pop_front();
                chk("rr_rsp_id", rr_if.rsp_id, rr_e.rid);
                chk("rr_rsp_out", rr_if.rsp_out, rr_e.rout);
                chk("rr_rsp_carry", rr_if.rsp_carry, rr_e.rcarry);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fp_if.req1_ready) fp_r1_seen++;
        if (rst_n && fp_if.rsp_valid && fp_if.rsp_ready) begin
            if (fp_q.size() == 0) begin
                chk("fp_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                fp_e = fp_q.pop_front();
                chk("fp_rsp_id", fp_if.rsp_id, fp_e.rid);
                chk("fp_rsp_out", fp_if.rsp_out, fp_e.rout);
                chk("fp_rsp_carry", fp_if.rsp_carry, fp_e.rcarry);
            end
        end
    end

    task automatic drive_req(input bit id, input logic v, input logic [2:0] op,
                             input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            rr_if.req0_valid = v;
            rr_if.req0_op    = op;
            rr_if.req0_a     = a;
            rr_if.req0_b     = b;
        end else begin
            rr_if.req1_valid = v;
            rr_if.req1_op    = op;
            rr_if.req1_a     = a;
            rr_if.req1_b     = b;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic do_op(input bit id, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        bit got = 1'b0;
        drive_req(id, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? rr_if.req1_ready : rr_if.req0_ready;
        end
        chk("grant_wait", got, 1);
        if (got) rr_q.push_back(mk(id, op, a, b));
        @(posedge clk);
        #1;
        // Scramble inputs after the handshake; only latched copies may matter.
        drive_req(id, 1'b0, ~op, ~a, ~b);
    endtask

    task automatic wait_idle(input string tag, input bit fp);
        bit idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            idle = fp ? (!busy_fp && !fp_if.rsp_valid) : (!busy_rr && !rr_if.rsp_valid);
        end
        chk(tag, idle, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        bit rr_m;
        bit exp_id;

        rst_n = 1'b0;
        drive_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        rr_if.rsp_ready  = 1'b1;
        fp_if.req0_valid = 1'b0;
        fp_if.req0_op    = 3'd0;
        fp_if.req0_a     = 4'd0;
        fp_if.req0_b     = 4'd0;
        fp_if.req1_valid = 1'b0;
        fp_if.req1_op    = 3'd0;
        fp_if.req1_a     = 4'd0;
        fp_if.req1_b     = 4'd0;
        fp_if.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_ready0", rr_if.req0_ready, 0);
        chk("rst_ready1", rr_if.req1_ready, 0);
        chk("rst_rsp_valid", rr_if.rsp_valid, 0);
        chk("rst_rsp_id", rr_if.rsp_id, 0);
        chk("rst_rsp_out", rr_if.rsp_out, 0);
        chk("rst_rsp_carry", rr_if.rsp_carry, 0);
        chk("rst_busy", busy_rr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin alternation with both requesters always valid
        rr_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_req(0, 1'b1, 3'd0, 4'(k), 4'd3);
            drive_req(1, 1'b1, 3'd4, 4'hF, 4'(k + 8));
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = rr_if.req0_ready | rr_if.req1_ready;
            end
            chk("rr_wait", got, 1);
            exp_id = ~rr_m;
            chk("rr_grant", {rr_if.req1_ready, rr_if.req0_ready}, exp_id ? 2'b10 : 2'b01);
            rr_q.push_back(exp_id ? mk(1'b1, 3'd4, 4'hF, 4'(k + 8)) : mk(1'b0, 3'd0, 4'(k), 4'd3));
            rr_m = exp_id;
            @(posedge clk);
            #1;
        end
        drive_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        wait_idle("rr_drain", 1'b0);

        // Fixed priority: req0 always wins
        fp_if.req0_valid = 1'b1;
        fp_if.req0_op    = 3'd0;
        fp_if.req0_a     = 4'd7;
        fp_if.req1_valid = 1'b1;
        fp_if.req1_op    = 3'd4;
        fp_if.req1_a     = 4'hF;
        fp_if.req1_b     = 4'hF;
        for (int k = 0; k < 4; k++) begin
            fp_if.req0_b = 4'(k * 3);
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = fp_if.req0_ready | fp_if.req1_ready;
            end
            chk("fp_wait", got, 1);
            chk("fp_grant", {fp_if.req1_ready, fp_if.req0_ready}, 2'b01);
            fp_q.push_back(mk(1'b0, 3'd0, 4'd7, 4'(k * 3)));
            @(posedge clk);
            #1;
        end
        fp_if.req0_valid = 1'b0;
        fp_if.req1_valid = 1'b0;
        wait_idle("fp_drain", 1'b1);
        chk("fp_req1_never_ready", fp_r1_seen, 0);

        // ADD 9+8 with latency check
        do_op(0, 3'd0, 4'd9, 4'd8);
        @(negedge clk);
        chk("lat_exec_valid", rr_if.rsp_valid, 0);
        chk("lat_exec_busy", busy_rr, 1);
        @(negedge clk);
        chk("lat_resp_valid", rr_if.rsp_valid, 1);
        @(posedge clk);
        #1;
        wait_idle("add_idle", 1'b0);

        // Op coverage from requester 1
        do_op(1, 3'd1, 4'd5, 4'd5);  wait_idle("eq_hit_idle", 1'b0);
        do_op(1, 3'd1, 4'd5, 4'd6);  wait_idle("eq_miss_idle", 1'b0);
        do_op(1, 3'd3, 4'd0, 4'd1);  wait_idle("neg_idle", 1'b0);
        do_op(1, 3'd2, 4'd9, 4'd0);  wait_idle("shr_idle", 1'b0);
        do_op(1, 3'd7, 4'hF, 4'd1);  wait_idle("ill_idle", 1'b0);
        do_op(0, 3'd4, 4'hE, 4'h7);  wait_idle("and_idle", 1'b0);

        // Back-pressure: response held 5 cycles, competing request not accepted
        rr_if.rsp_ready = 1'b0;
        do_op(0, 3'd4, 4'hC, 4'hA);
        drive_req(1, 1'b1, 3'd0, 4'd1, 4'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", rr_if.rsp_valid, 1);
            chk("stall_out", rr_if.rsp_out, 4'h8);
            chk("stall_carry", rr_if.rsp_carry, 1);
            chk("stall_id", rr_if.rsp_id, 0);
            chk("stall_busy", busy_rr, 1);
            chk("stall_ready", {rr_if.req1_ready, rr_if.req0_ready}, 2'b00);
        end
        @(posedge clk);
        #1;
        drive_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        rr_if.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_busy", busy_rr, 0);
        chk("release_valid", rr_if.rsp_valid, 0);
        @(posedge clk);
        #1;

        // Reset during EXEC: outputs clear at once, op discarded
        do_op(0, 3'd0, 4'd3, 4'd4);
        chk("pre_rst_busy", busy_rr, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_rr, 0);
        chk("mid_rst_valid", rr_if.rsp_valid, 0);
        chk("mid_rst_out", rr_if.rsp_out, 0);
        chk("mid_rst_ready", {rr_if.req1_ready, rr_if.req0_ready}, 2'b00);
        rr_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", rr_if.rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        do_op(1, 3'd0, 4'd2, 4'd3);
        wait_idle("post_rst_idle", 1'b0);

        chk("sb_empty", 32'(rr_q.size() + fp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
